// File: rtl/dibit_pkg.sv
// Shared definitions for the dibit serial link: FSM encoding and default geometry.
package dibit_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    localparam int unsigned DwDefault      = 8;
    localparam logic [1:0]  IdleSymDefault = 2'b11;

endpackage

// File: rtl/dibit_serializer_if.sv
// Parallel-word valid/ready handshake feeding the dibit serializer.
interface dibit_serializer_if
    import dibit_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) ();

    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_rdy;

    modport master (
        output din,
        output din_vld,
        input  din_rdy
    );

    modport slave (
        input  din,
        input  din_vld,
        output din_rdy
    );

endinterface

// File: rtl/dibit_serializer.sv
// Parallel-to-dibit serializer: MSB-first, one {A,B} pair per clock, with a one-word
// hold register so back-to-back words stream without bubbles.
module dibit_serializer
    import dibit_pkg::*;
#(
    parameter int unsigned DW       = DwDefault,
    parameter logic [1:0]  IDLE_SYM = IdleSymDefault
) (
    input  logic                clk,
    input  logic                clr,
    dibit_serializer_if.slave   in_if,
    output logic                A,
    output logic                B,
    output logic                sym_vld,
    output logic                busy,
    output logic [15:0]         word_cnt
);

    // A 1-bit counter is kept for DW=2 so the counter never has zero width.
    localparam int unsigned    CntW    = (DW > 2) ? $clog2(DW / 2) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DW / 2 - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     word_cnt_q, word_cnt_d;

    logic            accept;
    logic            cnt_last;

    assign in_if.din_rdy = ~hold_full_q;
    assign accept        = in_if.din_vld & ~hold_full_q;
    assign cnt_last      = (cnt_q == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StShift;
            end
            StShift: begin
                if (cnt_last && !hold_full_q && !accept) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        word_cnt_d  = word_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_d  = in_if.din;
                    cnt_d = CntLoad;
                end
            end
            StShift: begin
                if (!cnt_last) begin
                    sh_d  = sh_q << 2;
                    cnt_d = cnt_q - 1'b1;
                    if (accept) begin
                        hold_d      = in_if.din;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    // hold_full blocks din_rdy, so unload and accept are exclusive here.
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = CntLoad;
                    end else if (accept) begin
                        sh_d  = in_if.din;
                        cnt_d = CntLoad;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        A       = IDLE_SYM[1];
        B       = IDLE_SYM[0];
        sym_vld = 1'b0;
        if (state_q == StShift) begin
            A       = sh_q[DW-1];
            B       = sh_q[DW-2];
            sym_vld = 1'b1;
        end
    end

    assign busy     = (state_q == StShift) | hold_full_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_dibit_serializer.sv
// Self-checking bench for dibit_serializer: scoreboarded dibit stream, table-driven bursts,
// reset corner cases and a DW=2 gapless wrap run.
module tb_dibit_serializer;

    logic clk;
    logic clr;

    dibit_serializer_if #(.DW(8)) if8 ();
    dibit_serializer_if #(.DW(2)) if2 ();

    logic        a8, b8, sv8, busy8;
    logic [15:0] wc8;
    logic        a2, b2, sv2, busy2;
    logic [15:0] wc2;

    dibit_serializer #(.DW(8), .IDLE_SYM(2'b11)) u_dut (
        .clk      (clk),
        .clr      (clr),
        .in_if    (if8),
        .A        (a8),
        .B        (b8),
        .sym_vld  (sv8),
        .busy     (busy8),
        .word_cnt (wc8)
    );

    dibit_serializer #(.DW(2), .IDLE_SYM(2'b11)) u_dut2 (
        .clk      (clk),
        .clr      (clr),
        .in_if    (if2),
        .A        (a2),
        .B        (b2),
        .sym_vld  (sv2),
        .busy     (busy2),
        .word_cnt (wc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] dibs;   // expected dibits, first transmitted in [7:6]
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  sb[$];
    int          run_len  = 0;
    int          last_run = 0;
    int          z_cnt    = 0;
    logic [4:0]  hist     = '0;
    logic [15:0] exp_wc   = '0;
    vec_t        vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer plus a bit-serial 01110 reference detector on valid bits.
    task automatic monitor();
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (sv8 === 1'b1) begin
                run_len++;
                hist = {hist[3:0], a8};
                if (hist == 5'b01110) z_cnt++;
                hist = {hist[3:0], b8};
                if (hist == 5'b01110) z_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_symbol", {30'd0, a8, b8}, 32'hEE);
                end else begin
                    e = sb.pop_front();
                    check("dibit", {30'd0, a8, b8}, {30'd0, e});
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] dibs);
        bit ok = 0;
        for (int i = 0; i < 4; i++) sb.push_back(dibs[7-2*i -: 2]);
        if8.din     = w;
        if8.din_vld = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if8.din_rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        if8.din_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy8 && !sv8) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int z0;
        int errs;
        bit ok;

        vecs[0] = '{din: 8'h00, dibs: 8'b00_00_00_00};
        vecs[1] = '{din: 8'hFF, dibs: 8'b11_11_11_11};
        vecs[2] = '{din: 8'h96, dibs: 8'b10_01_01_10};
        vecs[3] = '{din: 8'h3C, dibs: 8'b00_11_11_00};

        if8.din = '0; if8.din_vld = 1'b0;
        if2.din = '0; if2.din_vld = 1'b0;
        clr = 1'b1;
        #2 clr = 1'b0;
        #1;
        // Reset state
        check("rst_ab", {30'd0, a8, b8}, 32'h3);
        check("rst_sym_vld", {31'd0, sv8}, 0);
        check("rst_busy", {31'd0, busy8}, 0);
        check("rst_word_cnt", {16'd0, wc8}, 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        #1 check("rst_din_rdy", {31'd0, if8.din_rdy}, 1);

        fork
            monitor();
        join_none

        // Single word with one-cycle latency and return to idle
        @(posedge clk); #1;
        send(8'b0111_0011, 8'b01_11_00_11);
        @(negedge clk);
        check("latency_sym_vld", {31'd0, sv8}, 1);
        check("latency_first_dibit", {30'd0, a8, b8}, 32'h1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("post_word_ab", {30'd0, a8, b8}, 32'h3);
        check("post_word_sym_vld", {31'd0, sv8}, 0);
        exp_wc = exp_wc + 16'd1;
        check("word_cnt_1", {16'd0, wc8}, {16'd0, exp_wc});

        // Back-to-back pair through the hold register
        @(posedge clk); #1;
        send(8'h5A, 8'b01_01_10_10);
        send(8'hC3, 8'b11_00_00_11);
        @(negedge clk);
        check("hold_full_rdy_low", {31'd0, if8.din_rdy}, 0);
        check("hold_full_busy", {31'd0, busy8}, 1);
        wait_idle();
        exp_wc = exp_wc + 16'd2;
        check("b2b_run_len", last_run, 8);
        check("b2b_word_cnt", {16'd0, wc8}, {16'd0, exp_wc});

        // Table-driven burst: the third word stalls on din_rdy
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(vecs[i].din, vecs[i].dibs);
        wait_idle();
        exp_wc = exp_wc + 16'd4;
        check("burst_run_len", last_run, 16);
        check("burst_word_cnt", {16'd0, wc8}, {16'd0, exp_wc});
        check("burst_sb_empty", sb.size(), 0);

        // Loopback pattern check against the 01110 reference detector
        z0 = z_cnt;
        @(posedge clk); #1;
        send(8'b0011_1000, 8'b00_11_10_00);
        wait_idle();
        check("detect_pulse", {31'd0, (z_cnt > z0)}, 1);
        z0 = z_cnt;
        @(posedge clk); #1;
        send(8'hFF, 8'b11_11_11_11);
        wait_idle();
        check("detect_quiet", z_cnt, z0);
        exp_wc = exp_wc + 16'd2;
        check("detect_word_cnt", {16'd0, wc8}, {16'd0, exp_wc});

        // Reset after two dibits of a word drops it immediately
        @(posedge clk); #1;
        send(8'hA5, 8'b10_10_01_01);
        repeat (2) @(negedge clk);
        #1 clr = 1'b0;
        #1;
        check("midrst_ab", {30'd0, a8, b8}, 32'h3);
        check("midrst_sym_vld", {31'd0, sv8}, 0);
        check("midrst_busy", {31'd0, busy8}, 0);
        check("midrst_word_cnt", {16'd0, wc8}, 0);
        sb.delete();
        exp_wc = '0;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1;
        send(8'h0F, 8'b00_00_11_11);
        wait_idle();
        exp_wc = exp_wc + 16'd1;
        check("postrst_run_len", last_run, 4);
        check("postrst_word_cnt", {16'd0, wc8}, {16'd0, exp_wc});

        // DW=2: 65536 words gapless, word_cnt wraps to 0
        @(posedge clk); #1;
        if2.din     = 2'b01;
        if2.din_vld = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sv2) begin
                ok = 1;
                break;
            end
        end
        check("dw2_start", {31'd0, ok}, 1);
        check("dw2_first_cnt", {16'd0, wc2}, 0);
        errs = 0;
        for (int k = 2; k <= 65536; k++) begin
            @(negedge clk);
            if (sv2 !== 1'b1 || {a2, b2} !== 2'b01) errs++;
        end
        check("dw2_gapless", errs, 0);
        check("dw2_cnt_ffff", {16'd0, wc2}, 32'hFFFF);
        @(negedge clk);
        check("dw2_wrap", {16'd0, wc2}, 0);
        check("dw2_still_vld", {31'd0, sv2}, 1);
        @(posedge clk); #1 if2.din_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("dw2_idle", {30'd0, sv2, busy2}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
